// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 data mux, with a per-grant
// burst limit and a valid/ready handshake toward a single downstream sink.
module mux_rr_arbiter #(
  parameter int DW       = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  input  logic [DW-1:0] din_c,
  input  logic [DW-1:0] din_d,
  input  logic          dout_ready,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] dout,
  output logic          dout_valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    gnt_reg, gnt_next;
  logic [1:0]    sel_reg, sel_next;
  logic [1:0]    prio_ptr_reg, prio_ptr_next;
  logic [CW-1:0] beat_cnt_reg, beat_cnt_next;

  logic [DW-1:0] din_arr [4];
  logic [1:0]    search_start;
  logic [1:0]    cand;
  logic [1:0]    win_idx;
  logic          win_found;
  logic [3:0]    win_onehot;
  logic          beat;
  logic          release_now;

  assign din_arr[0] = din_a;
  assign din_arr[1] = din_b;
  assign din_arr[2] = din_c;
  assign din_arr[3] = din_d;

  // From IDLE the search starts at the priority pointer; on release it starts
  // just past the current owner, so the owner itself is considered last.
  assign search_start = (state_reg == GRANT) ? sel_reg + 2'd1 : prio_ptr_reg;

  always_comb begin
    win_found = 1'b0;
    win_idx   = search_start;
    cand      = search_start;
    for (int j = 0; j < 4; j++) begin
      cand = search_start + 2'(j);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = win_found && (win_idx == 2'(gi));
    end
  endgenerate

  assign beat        = (state_reg == GRANT) && req[sel_reg] && dout_ready;
  assign release_now = (state_reg == GRANT) &&
                       (!req[sel_reg] || (beat && beat_cnt_reg == CW'(MAX_HOLD - 1)));

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    prio_ptr_next = prio_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next    = GRANT;
          gnt_next      = win_onehot;
          sel_next      = win_idx;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          prio_ptr_next = sel_reg + 2'd1;
          beat_cnt_next = '0;
          if (win_found) begin
            gnt_next = win_onehot;
            sel_next = win_idx;
          end else begin
            // sel keeps the last owner while idle
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (beat) begin
          beat_cnt_next = beat_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      prio_ptr_reg <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      prio_ptr_reg <= prio_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign gnt        = gnt_reg;
  assign sel        = sel_reg;
  assign dout       = din_arr[sel_reg];
  assign dout_valid = (gnt_reg != 4'd0) && req[sel_reg];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural owner/burst model.
module tb_mux_rr_arbiter;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] din_a, din_b, din_c, din_d;
  logic          dout_ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // model: current owner (-1 = idle), accepted beats this grant, rr pointer, last owner
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_last  = 0;

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
    .dout_ready(dout_ready),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int j = 0; j < 4; j++) begin
      if (r[(start + j) % 4]) return (start + j) % 4;
    end
    return -1;
  endfunction

  function automatic int din_of(input int idx);
    case (idx)
      0: return int'(din_a);
      1: return int'(din_b);
      2: return int'(din_c);
      default: return int'(din_d);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_held  <= 0;
      m_ptr   <= 0;
      m_last  <= 0;
    end else if (m_owner < 0) begin
      m_owner <= pick(req, m_ptr);
      m_held  <= 0;
    end else if (!req[m_owner] || (dout_ready && m_held + 1 == MAX_HOLD)) begin
      m_ptr   <= (m_owner + 1) % 4;
      m_owner <= pick(req, (m_owner + 1) % 4);
      m_last  <= m_owner;
      m_held  <= 0;
    end else if (dout_ready) begin
      m_held <= m_held + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      int es;
      es = (m_owner < 0) ? m_last : m_owner;
      check("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
      check("sel", int'(sel), es);
      check("dout_valid", int'(dout_valid), (m_owner >= 0 && req[es]) ? 1 : 0);
      check("dout", int'(dout), din_of(es));
    end
  end

  initial begin
    rst = 1'b1; req = 4'd0; dout_ready = 1'b0;
    din_a = 4'h5; din_b = 4'h6; din_c = 4'hA; din_d = 4'hD;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_sel", int'(sel), 0);
    check("reset_valid", int'(dout_valid), 0);
    check("reset_dout", int'(dout), 5);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // single requester c, held past MAX_HOLD beats
    req = 4'b0100; dout_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_gnt", int'(gnt), 4'b0100);
    check("t2_sel", int'(sel), 2);
    check("t2_dout", int'(dout), 4'hA);
    check("t2_valid", int'(dout_valid), 1);
    repeat (12) @(posedge clk);
    #1 check("t2_hold_gnt", int'(gnt), 4'b0100);

    // idle, then wake with pointer past requester 2
    #1 req = 4'b0000;
    @(posedge clk); #1;
    check("t6_idle_gnt", int'(gnt), 0);
    check("t6_idle_sel", int'(sel), 2);
    check("t6_idle_valid", int'(dout_valid), 0);
    #1 req = 4'b0101;
    @(posedge clk); #1;
    check("t6_wake_gnt", int'(gnt), 4'b0001);

    // reset mid-burst with all requesting
    #1 req = 4'hF; rst = 1'b1;
    #1;
    check("t1_async_gnt", int'(gnt), 0);
    check("t1_async_sel", int'(sel), 0);
    check("t1_async_valid", int'(dout_valid), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t1_first_gnt", int'(gnt), 4'b0001);

    // round robin with full bursts, no gap cycles
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < MAX_HOLD; b++) begin
        check("t3_owner", int'(gnt), 1 << (n % 4));
        @(posedge clk); #1;
      end
    end

    // sink stall on owner 0
    #1 rst = 1'b1; dout_ready = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t5_gnt0", int'(gnt), 4'b0001);
    repeat (20) begin
      @(posedge clk); #1;
      check("t5_stall_gnt", int'(gnt), 4'b0001);
      check("t5_stall_valid", int'(dout_valid), 1);
    end
    #1 dout_ready = 1'b1;
    repeat (MAX_HOLD - 1) begin
      @(posedge clk); #1;
      check("t5_burst_gnt", int'(gnt), 4'b0001);
    end
    @(posedge clk); #1;
    check("t5_next_gnt", int'(gnt), 4'b0010);

    // owner 1 drops after 3 beats; idle requester 2 is skipped
    repeat (3) @(posedge clk);
    #2 req = 4'b1001;
    @(posedge clk); #1;
    check("t4_gnt", int'(gnt), 4'b1000);
    check("t4_sel", int'(sel), 3);
    repeat (MAX_HOLD - 1) begin
      @(posedge clk); #1;
      check("t4_fresh_cnt", int'(gnt), 4'b1000);
    end
    @(posedge clk); #1;
    check("t4_wrap_gnt", int'(gnt), 4'b0001);

    // randomized traffic, model checked on every negedge
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      req        = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      din_a = 4'($urandom); din_b = 4'($urandom);
      din_c = 4'($urandom); din_d = 4'($urandom);
    end
    @(posedge clk); #1;
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
